dcm_lock_sequencer: RTL and testbench
=====================================

// Module: dcm_lock_sequencer
// PURPOSE
//  Reset/lock sequencer downstream of the DCM clock manager. Runs on the free-running board clock.
//  - drives the DCM asynchronous reset input
//  - consumes the DCM LOCKED and STATUS outputs
//  - holds the system reset (SYS_RST) until the synthesized clock has been stably locked
//  - retries the DCM on lock timeout or lock loss; flags permanent failure after MAX_RETRIES
// PARAMETERS
//  RST_PULSE      4       cycles DCM_RST is held high per attempt (>=3 required by DCM)
//  LOCK_TIMEOUT   100000  cycles to wait for synced LOCKED before retry (1 ms @100 MHz)
//  STABLE_CYCLES  1024    consecutive synced LOCKED=1 cycles required before release
//  MAX_RETRIES    7       failed attempts before FAIL; 0 = retry forever
// PORTS
//  CLK        in   1  free-running 100 MHz board clock (same net as DCM CLKIN)
//  RST        in   1  synchronous, active-high reset
//  LOCKED     in   1  DCM LOCKED (asynchronous to CLK; synchronized internally)
//  CLKFX_STOP in   1  DCM STATUS[2], CLKFX stopped (async; used only with STATUS_MON_EN)
//  DCM_RST    out  1  reset to DCM RST pin
//  SYS_RST    out  1  system reset for logic on CLK_out domain, active-high
//  READY      out  1  high in RUN state
//  FAIL       out  1  sticky; retries exhausted
//  RETRIES    out  3  failed-attempt count, saturating at 7
// BEHAVIOUR
//  - One clock CLK; reset is synchronous and active-high on RST.
//  - Reset values: DCM_RST=1, SYS_RST=1, READY=0, FAIL=0, RETRIES=0; state=S_DCMRST, counters=0.
//  - LOCKED and CLKFX_STOP pass through 2-FF synchronizers (lk_s, fs_s); 2-cycle input latency.
//  - All outputs registered; state decode -> output change 1 cycle after transition.
//  - S_DCMRST:
//    - DCM_RST=1; count RST_PULSE cycles, then -> S_WAIT (cnt cleared).
//  - S_WAIT:
//    - DCM_RST=0; lk_s=1 -> S_STABLE (cnt cleared).
//    - cnt reaches LOCK_TIMEOUT-1 with lk_s=0 -> retry.
//  - S_STABLE:
//    - lk_s=0 on any cycle -> retry.
//    - STABLE_CYCLES consecutive lk_s=1 -> S_RUN.
//  - S_RUN:
//    - SYS_RST=0, READY=1.
//    - lk_s=0 -> SYS_RST=1 and READY=0 on the next edge, then retry.
//  - retry:
//    - RETRIES++ (saturating at 7).
//    - if MAX_RETRIES!=0 and new count==MAX_RETRIES -> S_FAIL; else -> S_DCMRST.
//  - S_FAIL: terminal until RST. DCM_RST=1, SYS_RST=1, FAIL=1.
//  - Simultaneous events:
//    - timeout and lock rising on the same cycle: lock wins (-> S_STABLE).
//    - RST overrides everything.
//  - RST asserted mid-sequence: full restart from S_DCMRST; RETRIES and FAIL cleared.
//  - SYS_RST is 1 in every state except S_RUN. Glitch-free: register output only.
//  - Counter width: $clog2(max(LOCK_TIMEOUT,STABLE_CYCLES)+1); single shared cnt, cleared on
//    every state change.
// CONFIGURATION
//  - STATUS_MON_EN defined:
//    - fs_s=1 in S_STABLE or S_RUN is treated as lock loss (retry), even if lk_s=1.
//  - STATUS_MON_EN undefined:
//    - CLKFX_STOP is ignored (port kept, unconnected internally).
//    - Lock loss is detected from LOCKED only.
// STRUCTURE
//  - Package dcm_mgr_pkg:
//    - state encoding localparams S_DCMRST=0, S_WAIT=1, S_STABLE=2, S_RUN=3, S_FAIL=4 (3-bit)
//    - RETRY_W=3
//    - DCM_MIN_RST_CYCLES=3 (elaboration check: RST_PULSE>=3)
//  - Sub-module sync_2ff (1-bit, reset value 0), instanced for LOCKED and CLKFX_STOP.
//  - Single FSM always block plus registered output decode.
// TESTING
//  - Bench uses LOCK_TIMEOUT=50, STABLE_CYCLES=16, MAX_RETRIES=3, RST_PULSE=4.
//  - 1 Release after RST:
//    - stimulus: RST 2 cycles; LOCKED rises 20 cycles after DCM_RST falls.
//    - response: DCM_RST high exactly 4 cycles; SYS_RST falls and READY rises 2+16+1 cycles
//      after LOCKED rise; RETRIES=0.
//  - 2 Lock timeout:
//    - stimulus: LOCKED held 0.
//    - response: DCM_RST re-pulses every 4+50 cycles; RETRIES 1,2,3; FAIL=1 after third
//      timeout; DCM_RST stays 1.
//  - 3 Stability glitch:
//    - stimulus: LOCKED drops for 3 cycles at cycle 10 of S_STABLE.
//    - response: RETRIES=1, new DCM_RST pulse, SYS_RST never deasserted.
//  - 4 Lock loss in RUN:
//    - stimulus: LOCKED 1->0 while READY=1.
//    - response: SYS_RST=1 and READY=0 within 3 cycles (2 sync + 1); DCM_RST pulse follows;
//      re-lock returns to RUN.
//  - 5 Mid-sequence reset:
//    - stimulus: RST asserted during S_STABLE with RETRIES=2.
//    - response: next cycle DCM_RST=1, RETRIES=0, FAIL=0, sequence restarts.
//  - 6 STATUS_MON_EN:
//    - stimulus: CLKFX_STOP=1 in RUN with LOCKED=1.
//    - defined -> SYS_RST=1 and retry; undefined -> READY stays 1.

Source files
------------

// File: rtl/dcm_mgr_pkg.sv
// Shared types and constants for the DCM reset/lock sequencer.
// State encoding, retry counter width and the DCM minimum reset-pulse length live here.
package dcm_mgr_pkg;

    typedef enum logic [2:0] {
        S_DCMRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_e;

    localparam int RETRY_W            = 3;
    localparam int DCM_MIN_RST_CYCLES = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The failed-attempt count sticks at all-ones rather than wrapping back to zero.
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == '1) ? v : v + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/dcm_lock_sequencer_if.sv
// Signals between the lock sequencer and the DCM / downstream reset tree.
// master = the sequencer, slave = the DCM and the logic it resets.
interface dcm_lock_sequencer_if;
    import dcm_mgr_pkg::*;

    logic               locked;
    logic               clkfx_stop;
    logic               dcm_rst;
    logic               sys_rst;
    logic               ready;
    logic               fail;
    logic [RETRY_W-1:0] retries;

    modport master (
        input  locked,
        input  clkfx_stop,
        output dcm_rst,
        output sys_rst,
        output ready,
        output fail,
        output retries
    );

    modport slave (
        output locked,
        output clkfx_stop,
        input  dcm_rst,
        input  sys_rst,
        input  ready,
        input  fail,
        input  retries
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk_i domain.
// Resets to 0 so an unknown LOCKED never looks like a lock.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments make both flops sample the old values, so the
    // chain really is two stages deep; blocking here would collapse it to one flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dcm_lock_sequencer.sv
// Reset/lock sequencer for a DCM: pulses DCM_RST, waits for a stable lock, releases SYS_RST.
// Define STATUS_MON_EN to also treat CLKFX_STOP as lock loss in S_STABLE and S_RUN.
module dcm_lock_sequencer
    import dcm_mgr_pkg::*;
#(
    parameter int RST_PULSE     = 4,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dcm_lock_sequencer_if.master dcm_if
);

    localparam int CNT_MAX = max_int(LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    if (RST_PULSE < DCM_MIN_RST_CYCLES) begin : g_bad_rst_pulse
        $error("RST_PULSE must be at least %0d cycles", DCM_MIN_RST_CYCLES);
    end
    if (RST_PULSE > CNT_MAX) begin : g_bad_rst_range
        $error("RST_PULSE must not exceed max(LOCK_TIMEOUT, STABLE_CYCLES)");
    end
    if (LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_counts
        $error("LOCK_TIMEOUT and STABLE_CYCLES must be at least 1");
    end
    if (MAX_RETRIES < 0 || MAX_RETRIES > (2**RETRY_W) - 1) begin : g_bad_retries
        $error("MAX_RETRIES must be in 0..%0d", (2**RETRY_W) - 1);
    end

    logic lk_s;
    logic lock_lost;

    sync_2ff u_sync_lk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (dcm_if.locked),
        .q_o   (lk_s)
    );

`ifdef STATUS_MON_EN
    logic fs_s;

    sync_2ff u_sync_fs (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (dcm_if.clkfx_stop),
        .q_o   (fs_s)
    );

    // A stopped CLKFX means the synthesized clock is gone even if LOCKED still reads 1.
    assign lock_lost = !lk_s || fs_s;
`else
    assign lock_lost = !lk_s;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retries_q, retries_d;
    logic               retry;
    logic               dcm_rst_q, dcm_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;

    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        retry     = 1'b0;

        case (state_q)
            S_DCMRST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_WAIT: begin
                // Lock is checked first so a lock arriving on the timeout cycle wins.
                if (lk_s)                      state_d = S_STABLE;
                else if (cnt_q == TIMEOUT_LAST) retry  = 1'b1;
                else                           cnt_d   = cnt_q + CNT_W'(1);
            end
            S_STABLE: begin
                if (lock_lost)                 retry   = 1'b1;
                else if (cnt_q == STABLE_LAST) state_d = S_RUN;
                else                           cnt_d   = cnt_q + CNT_W'(1);
            end
            S_RUN: begin
                if (lock_lost) retry = 1'b1;
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_DCMRST;
            end
        endcase

        if (retry) begin
            retries_d = sat_inc(retries_q);
            state_d   = (MAX_RETRIES != 0 && retries_d == RETRY_LIMIT) ? S_FAIL : S_DCMRST;
        end

        if (state_d != state_q) cnt_d = '0;

        // Outputs decode the next state so they flip on the same edge as the transition.
        dcm_rst_d = (state_d == S_DCMRST) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_DCMRST;
            cnt_q     <= '0;
            retries_q <= '0;
            dcm_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            dcm_rst_q <= dcm_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign dcm_if.dcm_rst = dcm_rst_q;
    assign dcm_if.sys_rst = sys_rst_q;
    assign dcm_if.ready   = ready_q;
    assign dcm_if.fail    = fail_q;
    assign dcm_if.retries = retries_q;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Directed bench for dcm_lock_sequencer with short timing parameters.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on rising edges.
module tb_dcm_lock_sequencer;
    import dcm_mgr_pkg::*;

    localparam int RST_PULSE     = 4;
    localparam int LOCK_TIMEOUT  = 50;
    localparam int STABLE_CYCLES = 16;
    localparam int MAX_RETRIES   = 3;

    typedef enum {P_SYS_RST, P_READY, P_DCM_RST, P_RETRIES} probe_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    dcm_lock_sequencer_if bus ();

    dcm_lock_sequencer #(
        .RST_PULSE     (RST_PULSE),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .dcm_if (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] probe(input probe_e sel);
        logic [2:0] v;
        v = '0;
        case (sel)
            P_SYS_RST: v = {2'b00, bus.sys_rst};
            P_READY:   v = {2'b00, bus.ready};
            P_DCM_RST: v = {2'b00, bus.dcm_rst};
            default:   v = bus.retries;
        endcase
        return v;
    endfunction

    // Falling edges elapsed until the probed output equals val; returns limit on timeout.
    task automatic count_until(input probe_e sel, input logic [2:0] val, input int limit,
                               output int n);
        n = 0;
        while (probe(sel) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Two reset edges; leaves the bench on the falling edge after the last one.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low_seen;
        int dcm_seen;

        bus.locked     = 1'b0;
        bus.clkfx_stop = 1'b0;

        // 1: release after reset
        apply_reset();
        check("rst_dcm_rst", bus.dcm_rst, 1);
        check("rst_sys_rst", bus.sys_rst, 1);
        check("rst_ready",   bus.ready,   0);
        check("rst_fail",    bus.fail,    0);
        check("rst_retries", bus.retries, 0);
        count_until(P_DCM_RST, 3'd0, 20, n);
        check("t1_dcm_rst_width", n, RST_PULSE);
        repeat (20) @(negedge clk);
        bus.locked = 1'b1;
        count_until(P_SYS_RST, 3'd0, 100, n);
        check("t1_release_latency", n, 2 + STABLE_CYCLES + 1);
        check("t1_ready",   bus.ready,   1);
        check("t1_retries", bus.retries, 0);
        check("t1_dcm_rst", bus.dcm_rst, 0);

        // 4: lock loss while running, then re-lock
        bus.locked = 1'b0;
        count_until(P_SYS_RST, 3'd1, 20, n);
        check("t4_sys_rst_latency", n, 3);
        check("t4_ready",   bus.ready,   0);
        check("t4_dcm_rst", bus.dcm_rst, 1);
        check("t4_retries", bus.retries, 1);
        repeat (10) @(negedge clk);
        bus.locked = 1'b1;
        count_until(P_READY, 3'd1, 200, n);
        check("t4_relock_ready",   bus.ready,   1);
        check("t4_relock_sys_rst", bus.sys_rst, 0);
        check("t4_relock_retries", bus.retries, 1);

        // 3: LOCKED glitch during S_STABLE
        bus.locked = 1'b0;
        apply_reset();
        count_until(P_DCM_RST, 3'd0, 20, n);
        bus.locked = 1'b1;
        repeat (12) @(negedge clk);
        bus.locked = 1'b0;
        low_seen = 0;
        dcm_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!bus.sys_rst) low_seen++;
            if (bus.dcm_rst) dcm_seen++;
        end
        bus.locked = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!bus.sys_rst) low_seen++;
            if (bus.dcm_rst) dcm_seen++;
        end
        check("t3_sys_rst_low_cycles", low_seen, 0);
        check("t3_dcm_rst_pulse_len",  dcm_seen, RST_PULSE);
        check("t3_retries",            bus.retries, 1);
        check("t3_fail",               bus.fail, 0);

        // 5: reset in S_STABLE with two retries already counted
        bus.locked = 1'b0;
        apply_reset();
        count_until(P_RETRIES, 3'd2, 300, n);
        check("t5_retries_before", bus.retries, 2);
        bus.locked = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_sys_rst_before", bus.sys_rst, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_dcm_rst", bus.dcm_rst, 1);
        check("t5_retries", bus.retries, 0);
        check("t5_fail",    bus.fail,    0);
        check("t5_sys_rst", bus.sys_rst, 1);
        rst = 1'b0;
        count_until(P_READY, 3'd1, 100, n);
        check("t5_restart_latency", n, RST_PULSE + 1 + STABLE_CYCLES);
        check("t5_restart_retries", bus.retries, 0);

        // 2: LOCKED never rises, three timeouts then FAIL
        bus.locked = 1'b0;
        apply_reset();
        for (int k = 1; k <= MAX_RETRIES; k++) begin
            count_until(P_DCM_RST, 3'd0, 20, n);
            check($sformatf("t2_dcm_rst_high_%0d", k), n, RST_PULSE);
            count_until(P_DCM_RST, 3'd1, 200, n);
            check($sformatf("t2_dcm_rst_low_%0d", k), n, LOCK_TIMEOUT);
            check($sformatf("t2_retries_%0d", k), bus.retries, k);
            check($sformatf("t2_fail_%0d", k), bus.fail, (k == MAX_RETRIES) ? 1 : 0);
        end
        repeat (100) @(negedge clk);
        check("t2_final_dcm_rst", bus.dcm_rst, 1);
        check("t2_final_fail",    bus.fail,    1);
        check("t2_final_sys_rst", bus.sys_rst, 1);
        check("t2_final_retries", bus.retries, MAX_RETRIES);

        // 6: CLKFX_STOP while running with LOCKED high
        bus.locked = 1'b1;
        apply_reset();
        count_until(P_READY, 3'd1, 100, n);
        check("t6_ready_before", bus.ready, 1);
        bus.clkfx_stop = 1'b1;
`ifdef STATUS_MON_EN
        count_until(P_SYS_RST, 3'd1, 20, n);
        check("t6_sys_rst_latency", n, 3);
        check("t6_retries", bus.retries, 1);
        check("t6_dcm_rst", bus.dcm_rst, 1);
`else
        repeat (10) @(negedge clk);
        check("t6_ready_held",   bus.ready,   1);
        check("t6_sys_rst_held", bus.sys_rst, 0);
        check("t6_retries",      bus.retries, 0);
`endif
        bus.clkfx_stop = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
